// File: rtl/timer_bank_if.sv
// Bus-side connection of the multi-channel timer: processor strobes,
// address, write/read data and the combined interrupt request.
interface timer_bank_if #(
  parameter int BITS = 32
);
  logic            we;
  logic            re;
  logic [BITS-1:0] memAddr;
  logic [BITS-1:0] dataBusIn;
  logic [BITS-1:0] dataBusOut;
  logic            irq;

  modport master (
    output we, re, memAddr, dataBusIn,
    input  dataBusOut, irq
  );

  modport slave (
    input  we, re, memAddr, dataBusIn,
    output dataBusOut, irq
  );
endinterface

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer. NUM_CH independent channels, each
// with CNT / LIM / CTRL registers, share one tick prescaler. Each channel
// occupies 16 bytes starting at BASE. Reads are combinational and return
// zero when this block is not addressed, so the output can be OR-combined
// onto the shared bus.
module timer_bank #(
  parameter int              BITS        = 32,
  parameter int              NUM_CH      = 4,
  parameter logic [BITS-1:0] BASE        = 32'hF0000020,
  parameter int              TICK_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        reset,
  timer_bank_if.slave bus
);

  localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  // Prescaler and tick
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == TICK_LAST);

  // Free-running prescaler; raises tick for one cycle per period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (!reset)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Address decode: word-aligned offsets inside the populated channels only.
  // Addresses below BASE wrap to huge offsets and fail the range compare.
  logic [BITS-1:0] w_off;
  logic            w_dec;
  logic [2:0]      w_ch;
  logic [1:0]      w_reg;

  assign w_off = bus.memAddr - BASE;
  assign w_dec = (w_off < BITS'(16 * NUM_CH)) && (w_off[1:0] == 2'b00);
  assign w_ch  = w_off[6:4];
  assign w_reg = w_off[3:2];

  // Channel state
  logic [BITS-1:0]   r_cnt [NUM_CH];
  logic [BITS-1:0]   r_lim [NUM_CH];
  logic [NUM_CH-1:0] r_ready, r_ovf, r_en, r_os, r_ie;
  logic              r_irq;

  logic [NUM_CH-1:0] w_wr_cnt, w_wr_lim, w_wr_ctrl, w_clr_rdy, w_wrap;

  // Per-channel write strobes from the bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_wr_cnt  = '0;
    w_wr_lim  = '0;
    w_wr_ctrl = '0;
    w_clr_rdy = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.we && w_dec && (w_ch == 3'(c))) begin
        case (w_reg)
          2'd0:    w_wr_cnt[c]  = 1'b1;
          2'd1:    w_wr_lim[c]  = 1'b1;
          2'd2:    w_wr_ctrl[c] = 1'b1;
          default: ;
        endcase
      end
      w_clr_rdy[c] = w_wr_ctrl[c] && !bus.dataBusIn[0];
    end
  end

  // Wrap event: tick while enabled with CNT at LIM-1 or beyond. A CPU write
  // to CNT in the same cycle suppresses both the increment and the wrap.
  always_comb begin
    w_wrap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wrap[c] = w_tick && r_en[c] && !w_wr_cnt[c] && (r_lim[c] != '0) &&
                  (r_cnt[c] >= r_lim[c] - BITS'(1));
    end
  end

  // Channel registers: CPU writes, counting, sticky status and irq.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: these are ordinary flops (not a RAM), so the whole bank is
      // cleared in one loop; a reset mid-count leaves no status behind.
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]   <= '0;
        r_lim[c]   <= '0;
        r_ready[c] <= 1'b0;
        r_ovf[c]   <= 1'b0;
        r_en[c]    <= 1'b0;
        r_os[c]    <= 1'b0;
        r_ie[c]    <= 1'b0;
      end
      r_irq <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_cnt[c])              r_cnt[c] <= bus.dataBusIn;
        else if (w_wrap[c])           r_cnt[c] <= '0;
        else if (w_tick && r_en[c])   r_cnt[c] <= r_cnt[c] + BITS'(1);

        if (w_wr_lim[c]) r_lim[c] <= bus.dataBusIn;

        // Set beats clear; a clear coinciding with a wrap acts as an
        // acknowledge of the previous ready, so overflow is not raised.
        if (w_wrap[c])         r_ready[c] <= 1'b1;
        else if (w_clr_rdy[c]) r_ready[c] <= 1'b0;

        if (w_wrap[c]) begin
          if (r_ready[c] && !w_clr_rdy[c]) r_ovf[c] <= 1'b1;
        end else if (w_wr_ctrl[c] && !bus.dataBusIn[2]) begin
          r_ovf[c] <= 1'b0;
        end

        // CPU write of en wins over the one-shot self-disable.
        if (w_wr_ctrl[c]) begin
          r_en[c] <= bus.dataBusIn[4];
          r_os[c] <= bus.dataBusIn[5];
          r_ie[c] <= bus.dataBusIn[8];
        end else if (w_wrap[c] && r_os[c]) begin
          r_en[c] <= 1'b0;
        end
      end
      r_irq <= |(r_ready & r_ie);
    end
  end

  // Combinational read mux; zero unless this block is read.
  always_comb begin
    bus.dataBusOut = '0;
    if (bus.re && w_dec) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch == 3'(c)) begin
          case (w_reg)
            2'd0: bus.dataBusOut = r_cnt[c];
            2'd1: bus.dataBusOut = r_lim[c];
            2'd2: begin
              bus.dataBusOut[0] = r_ready[c];
              bus.dataBusOut[2] = r_ovf[c];
              bus.dataBusOut[4] = r_en[c];
              bus.dataBusOut[5] = r_os[c];
              bus.dataBusOut[8] = r_ie[c];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.irq = r_irq;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank with a 4-cycle tick. Register reads
// push their expected value onto a scoreboard queue; a negedge monitor pops
// and compares when the DUT presents read data. The bench keeps its own
// prescaler phase so stimulus can land on or away from tick edges.
module tb_timer_bank;

  localparam int          TICK = 4;
  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'hF0000020;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  timer_bank_if #(.BITS(32)) bus ();

  timer_bank #(
    .BITS(32), .NUM_CH(NCH), .BASE(BASE), .TICK_CYCLES(TICK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tb_presc = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  function automatic logic [31:0] ra(input int c, input int r);
    return BASE + 32'(16 * c + 4 * r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected prescaler phase: 0..TICK-1, tick edge ends the TICK-1 cycle.
  always @(posedge clk) begin
    if (!reset) tb_presc <= 0;
    else        tb_presc <= (tb_presc == TICK - 1) ? 0 : tb_presc + 1;
  end

  // Scoreboard monitor: compare read data, and idle-bus zero otherwise.
  always @(negedge clk) begin : mon
    sb_t e;
    if (bus.re) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: read with no expected entry at %h", bus.memAddr);
      end else begin
        e = sb_q.pop_front();
        check(e.name, bus.dataBusOut, e.exp);
      end
    end else begin
      check("idle_bus", bus.dataBusOut, 32'h0);
    end
  end

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    bus.re      = 1'b1;
    bus.memAddr = addr;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.we        = 1'b1;
    bus.memAddr   = addr;
    bus.dataBusIn = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic chk_irq(input string name, input logic exp);
    @(negedge clk);
    check(name, {31'b0, bus.irq}, {31'b0, exp});
    @(posedge clk);
    #1;
  endtask

  // Advance to the cycle whose closing edge is a tick edge (bounded).
  task automatic wait_tick_cycle();
    for (int i = 0; i < 2 * TICK; i++) begin
      if (tb_presc == TICK - 1) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL tick_wait: no tick phase within %0d cycles", 2 * TICK);
  endtask

  // Pass one tick edge; returns in the first cycle after it.
  task automatic after_tick();
    wait_tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) after_tick();
  endtask

  initial begin : timeout
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, ra(0, 0),        32'h0,        32'h0};
    vecs[1]  = '{1'b0, ra(0, 1),        32'h0,        32'h0};
    vecs[2]  = '{1'b0, ra(0, 2),        32'h0,        32'h0};
    vecs[3]  = '{1'b0, ra(NCH, 0),      32'h0,        32'h0};
    vecs[4]  = '{1'b1, ra(0, 2),        32'hFFFF_FECF, 32'h0};
    vecs[5]  = '{1'b1, ra(1, 2),        32'h0000_0125, 32'h0000_0120};
    vecs[6]  = '{1'b1, ra(0, 3),        32'h0000_DEAD, 32'h0};
    vecs[7]  = '{1'b1, ra(2, 1),        32'h0000_0055, 32'h0000_0055};
    vecs[8]  = '{1'b1, ra(1, 0),        32'h0000_0007, 32'h0000_0007};
    vecs[9]  = '{1'b1, ra(NCH, 0),      32'h0000_1234, 32'h0};
    vecs[10] = '{1'b0, BASE + 32'd1,    32'h0,        32'h0};
    vecs[11] = '{1'b1, BASE - 32'd16,   32'h0000_0005, 32'h0};
    vecs[12] = '{1'b1, ra(1, 2),        32'h0,        32'h0};
    vecs[13] = '{1'b1, ra(2, 1),        32'h0,        32'h0};
    vecs[14] = '{1'b1, ra(1, 0),        32'h0,        32'h0};

    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.memAddr   = '0;
    bus.dataBusIn = '0;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_irq("rst_irq", 1'b0);

    // Reset state, register map, masks and undecoded addresses
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Periodic count on channel 0, LIM=3
    wr(ra(0, 1), 32'd3);
    wr(ra(0, 2), 32'h010);
    after_tick();  rd("p_cnt_t1", ra(0, 0), 32'd1);
    after_tick();  rd("p_cnt_t2", ra(0, 0), 32'd2);
    after_tick();  rd("p_cnt_t3", ra(0, 0), 32'd0);
    rd("p_ctrl_wrap1", ra(0, 2), 32'h011);
    ticks(3);
    rd("p_ctrl_wrap2", ra(0, 2), 32'h015);

    // Clear status, enable irq, then wrap and acknowledge
    wr(ra(0, 2), 32'h110);
    rd("clr_ctrl", ra(0, 2), 32'h110);
    chk_irq("irq_low", 1'b0);
    ticks(2);
    rd("irq_ctrl", ra(0, 2), 32'h111);
    chk_irq("irq_high", 1'b1);
    wr(ra(0, 2), 32'h110);
    @(posedge clk);
    #1;
    chk_irq("irq_clear", 1'b0);

    // One-shot on channel 1 while channel 0 keeps counting
    after_tick();
    wr(ra(0, 0), 32'd0);
    wr(ra(1, 1), 32'd2);
    wr(ra(1, 2), 32'h030);
    after_tick();  rd("os_cnt_t1", ra(1, 0), 32'd1);
    after_tick();
    rd("os_cnt_t2", ra(1, 0), 32'd0);
    rd("os_ctrl", ra(1, 2), 32'h021);
    rd("os_ch0_t2", ra(0, 0), 32'd2);
    for (int i = 1; i <= 10; i++) begin
      after_tick();
      if (i == 5) rd("os_ch0_t7", ra(0, 0), 32'd1);
    end
    rd("os_cnt_hold", ra(1, 0), 32'd0);
    rd("os_ctrl_hold", ra(1, 2), 32'h021);
    rd("os_ch0_t12", ra(0, 0), 32'd0);
    rd("os_ch0_ctrl", ra(0, 2), 32'h115);

    // Collisions on channel 2: CNT write on tick, ready clear on wrap
    wr(ra(2, 2), 32'h010);
    wait_tick_cycle();
    wr(ra(2, 0), 32'd100);
    rd("col_cnt_wr", ra(2, 0), 32'd100);
    wr(ra(2, 1), 32'd2);
    after_tick();  rd("col_wrap_ctrl", ra(2, 2), 32'h011);
    after_tick();  rd("col_cnt1", ra(2, 0), 32'd1);
    wait_tick_cycle();
    wr(ra(2, 2), 32'h010);
    rd("col_clr_ctrl", ra(2, 2), 32'h011);
    rd("col_clr_cnt", ra(2, 0), 32'd0);

    // One-shot wrap vs CPU writing en=1 on channel 1
    after_tick();
    wr(ra(1, 0), 32'd1);
    wr(ra(1, 2), 32'h030);
    wait_tick_cycle();
    wr(ra(1, 2), 32'h031);
    rd("en_col_ctrl", ra(1, 2), 32'h031);
    after_tick();  rd("en_col_run", ra(1, 0), 32'd1);

    // Free-running channel 3 wraps from all-ones without status
    after_tick();
    wr(ra(3, 0), 32'hFFFF_FFFF);
    wr(ra(3, 2), 32'h010);
    after_tick();
    rd("fr_cnt", ra(3, 0), 32'd0);
    rd("fr_ctrl", ra(3, 2), 32'h010);

    // Reset mid-operation clears everything
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk_irq("rst2_irq", 1'b0);
    for (int c = 0; c < NCH; c++) begin
      for (int r = 0; r < 3; r++) begin
        rd($sformatf("rst2_c%0d_r%0d", c, r), ra(c, r), 32'h0);
      end
    end

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Multi-channel memory-mapped timer peripheral on the shared processor data bus.
- It generalises the single-channel timer to NUM_CH independent channels behind one shared tick prescaler.
- Each channel has a count register, a limit register and a control register.
- New over the single-channel timer: one-shot mode, per-channel enable, sticky ready/overflow status, and a combined interrupt request.
- Sits beside memory, LED, HEX, key and switch devices; its dataBusOut is OR-combined onto the bus.

Parameters:
- BITS, 32: bus width and width of every channel register.
- NUM_CH, 4: number of channels, legal range 1..8.
- BASE, 32'hF0000020: address of channel 0 CNT. Channel c occupies BASE+16*c .. BASE+16*c+12.
- TICK_CYCLES, 25000: clk cycles per timer tick (1 ms at a 40 ns clock); minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- we  in  1  bus write strobe.
- re  in  1  bus read strobe.
- memAddr  in  BITS  bus byte address; full-width compare.
- dataBusIn  in  BITS  bus write data.
- dataBusOut  out  BITS  read data; all zeros whenever this block is not being read.
- irq  out  1  OR over channels of (ready & ie).

Behaviour:
- Register map for channel c (A = BASE+16*c):
  - A+0 CNT: read/write.
  - A+4 LIM: read/write.
  - A+8 CTRL.
  - A+12: reserved; reads 0, writes ignored.
- CTRL bits:
  - [0] ready: sticky; written 0 clears it; written 1 is ignored.
  - [2] overflow: sticky; same write-0-to-clear rule.
  - [4] en: plain read/write.
  - [5] oneshot: plain read/write.
  - [8] ie: plain read/write.
  - All other bits read 0.
- Addresses for channels >= NUM_CH are not decoded.
- Reset (reset==0 at a clk edge):
  - Every CNT, LIM, CTRL and the prescaler go to 0.
  - irq reads 0 from the following cycle.
  - Reset overrides any simultaneous we or tick.
  - Reset mid-count abandons the count with no status set.
- Reads are combinational: dataBusOut = addressed register when re==1 and the address is decoded, else 0. Reads have no side effects.
- Writes take effect at the clk edge where we==1 and the address is decoded; the new value is visible from the next cycle.
- Prescaler:
  - Free-running 0..TICK_CYCLES-1.
  - tick=1 for exactly the one cycle it equals TICK_CYCLES-1, then it wraps to 0.
  - The prescaler is shared by all channels and is unaffected by register writes.
- Channel update on a tick edge with en==1:
  - If LIM!=0 and CNT>=LIM-1: CNT<=0 and a "wrap" event occurs.
    - Wrap with ready already 1 sets overflow.
    - Wrap always sets ready.
    - Wrap with oneshot==1 also clears en, so CNT holds at 0.
  - Else: CNT<=CNT+1, modulo 2^BITS.
  - LIM==0 means free-running: the counter wraps from all-ones to 0 with no ready/overflow.
- en==0: CNT holds its value; ticks are ignored.
- Simultaneous events, same channel, same edge:
  - CPU write to CNT beats the tick: the written value is loaded and there is no increment or wrap that cycle.
  - CPU write to LIM takes effect for the next tick; the comparison in the same cycle uses the old LIM.
  - CPU clearing ready while a wrap occurs: ready=1 (set wins) and overflow is unchanged (the clear is treated as an acknowledge).
  - CPU writing en=1 in the same cycle that a one-shot wrap clears en: en=1 (CPU wins).
- Channels are fully independent apart from the shared tick.
- irq is registered from ready and ie; it lags a ready change by at most one cycle.

Test Plan:
- Reset and idle read. Drive reset=0 for 2 cycles, then re at BASE, BASE+4, BASE+8, and at address BASE+16*NUM_CH → dataBusOut=0 for every read; irq=0.
- Periodic count (TICK_CYCLES=4). Write LIM0=3, CTRL0=0x010 → CNT0 follows 0,1,2,0 on successive ticks; CTRL0 reads 0x011 after the first wrap; after a second wrap with no clear, reads 0x015.
- Clear and irq. With CTRL0 reading 0x015, write CTRL0=0x110 → reads 0x110 next cycle. After the next wrap it reads 0x111 and irq=1 one cycle later. Writing 0x110 again drops irq within 1 cycle.
- One-shot. Write LIM1=2, CTRL1=0x030 → after 2 ticks CNT1=0, CTRL1=0x021, and CNT1 stays 0 for 10 further ticks. Channel 0 keeps counting meanwhile.
- Collisions. In the exact tick cycle, write CNT2=100 → CNT2 reads 100, not 101. Clear ready in the same cycle as a wrap → ready stays 1 and overflow stays 0.
- Free-run and mid-operation reset. With LIM3=0, write CNT3=32'hFFFFFFFF and en=1 → the next tick gives CNT3=0 and CTRL3 ready=0. Assert reset=0 for one edge while counting → all registers read 0 afterwards.
